dht11_host: RTL and testbench

//  Host-side initiator for the DHT11 single-wire humidity/temperature bus.
//  - On request, drives the start pulse and releases the line.
//  - Checks the sensor's response preamble, then times 40 data bits.
//  - Verifies the checksum and presents humidity/temperature bytes.
//  - Sits between control logic and the shared open-drain pin; the dht11 sensor model is the other end.

---
 rtl/dht11_host.sv | 154 +++++++++++++++
 tb/tb_dht11_host.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dht11_host.sv
// DHT11 single-wire host: issues the start pulse, checks the sensor preamble,
// times 40 data bits on the synchronised line and publishes checksummed bytes.
module dht11_host #(
   parameter int unsigned START_LO_CYC = 18000,
   parameter int unsigned TIMEOUT_CYC  = 200,
   parameter int unsigned BIT_THRESH   = 48
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   inout  wire        data_io,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] tmp_int,
   output logic [7:0] tmp_dec
);

   typedef enum logic [3:0] {
      S_IDLE, S_START_LO, S_WAIT_RESP, S_RESP_LO, S_RESP_HI,
      S_BIT_LO, S_BIT_HI, S_CHECK, S_ERR
   } state_t;

   localparam logic [15:0] START_LAST = 16'(START_LO_CYC - 1);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);
   localparam logic [15:0] THRESH     = 16'(BIT_THRESH);
   localparam logic [15:0] SYNC_LAT   = 16'd2;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic        r_sync1;
   logic        r_sync2;
   logic [39:0] r_shift;
   logic [5:0]  r_idx;
   logic [1:0]  r_pend_code;
   logic [1:0]  w_code;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [1:0]  r_err_code;
   logic [7:0]  r_hum_int;
   logic [7:0]  r_hum_dec;
   logic [7:0]  r_tmp_int;
   logic [7:0]  r_tmp_dec;
   logic        w_timeout;
   logic [7:0]  w_sum;

   // Open-drain: only ever pull low, the external pullup supplies the high level.
   assign data_io = (r_state == S_START_LO) ? 1'b0 : 1'bz;

   assign w_timeout = (r_cnt >= TO_LAST);
   assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      w_next = r_state;
      w_code = r_pend_code;
      case (r_state)
         S_IDLE:      if (start && !r_done && !r_err) w_next = S_START_LO;
         S_START_LO:  if (r_cnt >= START_LAST) w_next = S_WAIT_RESP;
         // The synchroniser still holds our own start pulse for SYNC_LAT cycles.
         S_WAIT_RESP: begin
            if (!r_sync2 && r_cnt >= SYNC_LAT) w_next = S_RESP_LO;
            else if (w_timeout) begin w_next = S_ERR; w_code = 2'd1; end
         end
         S_RESP_LO: begin
            if (r_sync2) w_next = S_RESP_HI;
            else if (w_timeout) begin w_next = S_ERR; w_code = 2'd1; end
         end
         S_RESP_HI: begin
            if (!r_sync2) w_next = S_BIT_LO;
            else if (w_timeout) begin w_next = S_ERR; w_code = 2'd1; end
         end
         S_BIT_LO: begin
            if (r_sync2) w_next = S_BIT_HI;
            else if (w_timeout) begin w_next = S_ERR; w_code = 2'd2; end
         end
         S_BIT_HI: begin
            if (!r_sync2) w_next = (r_idx == 6'd39) ? S_CHECK : S_BIT_LO;
            else if (w_timeout) begin w_next = S_ERR; w_code = 2'd2; end
         end
         S_CHECK: begin
            if (w_sum == r_shift[7:0]) w_next = S_IDLE;
            else begin w_next = S_ERR; w_code = 2'd3; end
         end
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_shift     <= '0;
         r_idx       <= '0;
         r_pend_code <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= '0;
         r_hum_int   <= '0;
         r_hum_dec   <= '0;
         r_tmp_int   <= '0;
         r_tmp_dec   <= '0;
      end else begin
         // NOTE: non-blocking everywhere here so all state updates see pre-edge values.
         r_state     <= w_next;
         r_pend_code <= w_code;
         r_sync1     <= data_io;
         r_sync2     <= r_sync1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         if (w_next != r_state)     r_cnt <= '0;
         else if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;

         if (r_state == S_IDLE && w_next == S_START_LO) r_busy <= 1'b1;
         if (r_state == S_RESP_HI && w_next == S_BIT_LO) r_idx <= '0;
         if (r_state == S_BIT_HI && !r_sync2) begin
            r_shift <= {r_shift[38:0], (r_cnt >= THRESH)};
            r_idx   <= r_idx + 6'd1;
         end
         if (r_state == S_CHECK && w_next == S_IDLE) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_hum_int <= r_shift[39:32];
            r_hum_dec <= r_shift[31:24];
            r_tmp_int <= r_shift[23:16];
            r_tmp_dec <= r_shift[15:8];
         end
         if (r_state == S_ERR) begin
            r_err      <= 1'b1;
            r_err_code <= r_pend_code;
            r_busy     <= 1'b0;
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;
   assign err_code = r_err_code;
   assign hum_int  = r_hum_int;
   assign hum_dec  = r_hum_dec;
   assign tmp_int  = r_tmp_int;
   assign tmp_dec  = r_tmp_dec;

endmodule

// File: tb/tb_dht11_host.sv
// Directed bench for dht11_host with an inline behavioural DHT11 sensor model
// driving the shared open-drain line.
module tb_dht11_host;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       sens_low;
   wire        data_io;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;

   int total = 0;
   int bad   = 0;

   int   n_done = 0, n_err = 0, n_host_low = 0, n_busy_rise = 0, n_inj = 0;
   logic [1:0] last_code = '0;
   logic       err_busy_ok = 1'b0;
   logic       prev_busy = 1'b0;

   localparam logic [39:0] GOOD   = 40'h37_00_18_00_4F;
   localparam logic [39:0] BADSUM = 40'h37_00_18_00_50;
   localparam logic [39:0] FRAME6 = 40'h41_05_1A_09_69;

   always #5 clk = ~clk;

   pullup (data_io);
   assign data_io = sens_low ? 1'b0 : 1'bz;

   dht11_host #(.START_LO_CYC(20), .TIMEOUT_CYC(30), .BIT_THRESH(6)) dut (
      .clk(clk), .rst(rst), .start(start), .data_io(data_io),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec)
   );

   // Event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (data_io === 1'b0 && !sens_low) n_host_low++;
      if (done === 1'b1) n_done++;
      if (err === 1'b1) begin
         n_err++;
         last_code   = err_code;
         err_busy_ok = (busy === 1'b0) && (prev_busy === 1'b1);
      end
      if (busy === 1'b1 && prev_busy === 1'b0) n_busy_rise++;
      prev_busy = busy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      check("idle_reached", busy, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [39:0] frame, input int stuck_bit,
                             input int stop_bit, input int start_bit, input bit inject_done);
      int n = 0;
      while (data_io !== 1'b0 && n < 60) begin @(negedge clk); n++; end
      check("host_pulls_low", data_io, 1'b0);
      n = 0;
      while (data_io !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      check("host_releases", data_io, 1'b1);
      repeat (2) @(negedge clk);
      sens_low = 1'b1; repeat (8) @(negedge clk);
      sens_low = 1'b0; repeat (8) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (i == stop_bit) return;
         sens_low = 1'b1;
         if (i == start_bit) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (4) @(negedge clk);
         sens_low = 1'b0;
         if (i == stuck_bit) begin repeat (40) @(negedge clk); return; end
         repeat (frame[39-i] ? 9 : 3) @(negedge clk);
      end
      // Trailing low, then release; optionally re-request start during done.
      sens_low = 1'b1;
      for (int k = 0; k < 11; k++) begin
         if (k == 5) sens_low = 1'b0;
         start = inject_done && (done === 1'b1);
         if (start) n_inj++;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int d0, e0, h0, b0, lat;
      rst = 1'b1; start = 1'b0; sens_low = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_code", err_code, 2'd0);
      check("rst_hum_int", hum_int, 8'h00);
      check("rst_tmp_int", tmp_int, 8'h00);
      check("rst_line", data_io, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1. good frame
      d0 = n_done; e0 = n_err; h0 = n_host_low;
      pulse_start();
      send_frame(GOOD, -1, -1, -1, 1'b0);
      wait_idle();
      check("t1_done_cnt", n_done - d0, 1);
      check("t1_err_cnt", n_err - e0, 0);
      check("t1_low_cyc", n_host_low - h0, 20);
      check("t1_hum_int", hum_int, 8'h37);
      check("t1_hum_dec", hum_dec, 8'h00);
      check("t1_tmp_int", tmp_int, 8'h18);
      check("t1_tmp_dec", tmp_dec, 8'h00);

      // 2. no sensor
      d0 = n_done; e0 = n_err;
      pulse_start();
      lat = 1;
      while (err !== 1'b1 && lat < 53) begin @(negedge clk); lat++; end
      check("t2_err_in_time", err, 1'b1);
      check("t2_code", err_code, 2'd1);
      wait_idle();
      check("t2_err_cnt", n_err - e0, 1);
      check("t2_done_cnt", n_done - d0, 0);
      check("t2_hum_int", hum_int, 8'h37);
      check("t2_tmp_int", tmp_int, 8'h18);

      // 3. bad checksum
      d0 = n_done; e0 = n_err;
      pulse_start();
      send_frame(BADSUM, -1, -1, -1, 1'b0);
      wait_idle();
      check("t3_err_cnt", n_err - e0, 1);
      check("t3_code", last_code, 2'd3);
      check("t3_done_cnt", n_done - d0, 0);
      check("t3_hum_int", hum_int, 8'h37);
      check("t3_tmp_int", tmp_int, 8'h18);

      // 4. stuck bit 12
      e0 = n_err; err_busy_ok = 1'b0;
      pulse_start();
      send_frame(GOOD, 12, -1, -1, 1'b0);
      wait_idle();
      check("t4_err_cnt", n_err - e0, 1);
      check("t4_code", last_code, 2'd2);
      check("t4_busy_fall", err_busy_ok, 1'b1);

      // 5a. reset while the start pulse is being driven
      pulse_start();
      repeat (5) @(negedge clk);
      check("t5a_driving", data_io, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("t5a_released", data_io, 1'b1);
      check("t5a_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 5. reset at bit 20, then a good frame
      d0 = n_done; e0 = n_err;
      pulse_start();
      send_frame(GOOD, -1, 20, -1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("t5_released", data_io, 1'b1);
      check("t5_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("t5_no_done", n_done - d0, 0);
      check("t5_no_err", n_err - e0, 0);
      check("t5_hum_rst", hum_int, 8'h00);
      pulse_start();
      send_frame(GOOD, -1, -1, -1, 1'b0);
      wait_idle();
      check("t5_done_after", n_done - d0, 1);
      check("t5_hum_int", hum_int, 8'h37);

      // 6. start while busy and in the done cycle
      d0 = n_done; e0 = n_err; h0 = n_host_low; b0 = n_busy_rise;
      pulse_start();
      send_frame(FRAME6, -1, -1, 5, 1'b1);
      repeat (60) @(negedge clk);
      check("t6_injected", n_inj, 1);
      check("t6_done_cnt", n_done - d0, 1);
      check("t6_err_cnt", n_err - e0, 0);
      check("t6_busy_rises", n_busy_rise - b0, 1);
      check("t6_low_cyc", n_host_low - h0, 20);
      check("t6_hum_int", hum_int, 8'h41);
      check("t6_hum_dec", hum_dec, 8'h05);
      check("t6_tmp_int", tmp_int, 8'h1A);
      check("t6_tmp_dec", tmp_dec, 8'h09);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
